// File: rtl/dice_roller_bcd.sv
// Dice roller: per-button debounce, BCD roll counter that cycles N..1 while the
// button is held, and a saturating BCD running sum shown when not rolling.
module dice_roller_bcd #(
   parameter int DIGITS     = 3,
   parameter int DEB_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [5:0]          btn,
   input  logic                accum,
   input  logic                clear,
   output logic [4*DIGITS-1:0] result,
   output logic [2:0]          die,
   output logic                rolling,
   output logic                done,
   output logic                sat
);

   localparam int W = 4 * DIGITS;
   localparam logic [W-1:0] BCD_ONE   = {{(W-4){1'b0}}, 4'h1};
   localparam logic [W-1:0] BCD_NINES = {DIGITS{4'h9}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ROLL = 2'd1,
      S_DONE = 2'd2,
      S_LOCK = 2'd3
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic [5:0]   r_deb;
   logic [7:0]   r_deb_cnt [6];
   logic [2:0]   r_die;
   logic [W-1:0] r_cnt;
   logic [W-1:0] r_sum;
   logic         r_sat;
   logic [2:0]   w_first;
   logic [W:0]   w_add;

   // Die size in BCD; the 100 of a d100 truncates to 00 on a two-digit display.
   function automatic logic [W-1:0] die_size(input logic [2:0] d);
      logic [15:0] v;
      case (d)
         3'd0:    v = 16'h0004;
         3'd1:    v = 16'h0006;
         3'd2:    v = 16'h0008;
         3'd3:    v = 16'h0010;
         3'd4:    v = 16'h0020;
         3'd5:    v = 16'h0100;
         default: v = 16'h0004;
      endcase
      return v[W-1:0];
   endfunction

   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         b;
      r = v;
      b = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         if (b) begin
            if (v[4*d +: 4] == 4'd0) begin
               r[4*d +: 4] = 4'd9;
            end else begin
               r[4*d +: 4] = v[4*d +: 4] - 4'd1;
               b = 1'b0;
            end
         end else begin
            r[4*d +: 4] = v[4*d +: 4];
         end
      end
      return r;
   endfunction

   // Returns {carry_out, sum}; carry_out means the sum overflowed DIGITS digits.
   function automatic logic [W:0] bcd_add(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] s;
      logic         c;
      logic [4:0]   t;
      s = '0;
      c = 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
         t = {1'b0, a[4*d +: 4]} + {1'b0, b[4*d +: 4]} + {4'd0, c};
         if (t > 5'd9) begin
            t = t + 5'd6;
            c = 1'b1;
         end else begin
            c = 1'b0;
         end
         s[4*d +: 4] = t[3:0];
      end
      return {c, s};
   endfunction

   function automatic logic [2:0] first_set(input logic [5:0] b);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 5; i >= 0; i--) begin
         if (b[i]) begin
            r = 3'(i);
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   assign w_first = first_set(r_deb);
   assign w_add   = bcd_add(r_sum, r_cnt);

   // Debounce: a bit's level flips only after DEB_CYCLES straight differing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_deb <= 6'd0;
         for (int i = 0; i < 6; i++) begin
            r_deb_cnt[i] <= 8'd0;
         end
      end else begin
         for (int i = 0; i < 6; i++) begin
            if (btn[i] != r_deb[i]) begin
               if (r_deb_cnt[i] == 8'(DEB_CYCLES - 1)) begin
                  r_deb[i]     <= btn[i];
                  r_deb_cnt[i] <= 8'd0;
               end else begin
                  r_deb_cnt[i] <= r_deb_cnt[i] + 8'd1;
               end
            end else begin
               r_deb_cnt[i] <= 8'd0;
            end
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state; LOCK holds until every button is released.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (|r_deb) w_state_nxt = S_ROLL;
            else        w_state_nxt = S_IDLE;
         end
         S_ROLL: begin
            if (!r_deb[r_die]) w_state_nxt = S_DONE;
            else               w_state_nxt = S_ROLL;
         end
         S_DONE: begin
            if (|r_deb) w_state_nxt = S_LOCK;
            else        w_state_nxt = S_IDLE;
         end
         S_LOCK: begin
            if (r_deb == 6'd0) w_state_nxt = S_IDLE;
            else               w_state_nxt = S_LOCK;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Die latch and roll counter; counter freezes on the edge leaving ROLL.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_die <= 3'd0;
         r_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|r_deb) begin
                  r_die <= w_first;
                  r_cnt <= die_size(w_first);
               end else begin
                  r_die <= r_die;
                  r_cnt <= r_cnt;
               end
            end
            S_ROLL: begin
               if (r_deb[r_die]) begin
                  if (r_cnt == BCD_ONE) r_cnt <= die_size(r_die);
                  else                  r_cnt <= bcd_dec(r_cnt);
               end else begin
                  r_cnt <= r_cnt;
               end
            end
            default: begin
               r_die <= r_die;
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   // Running sum and sticky saturation flag; clear overrides the DONE update.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum <= '0;
         r_sat <= 1'b0;
      end else if (clear) begin
         r_sum <= '0;
         r_sat <= 1'b0;
      end else if (r_state == S_DONE) begin
         if (!accum) begin
            r_sum <= r_cnt;
         end else if (w_add[W]) begin
            r_sum <= BCD_NINES;
            r_sat <= 1'b1;
         end else begin
            r_sum <= w_add[W-1:0];
         end
      end else begin
         r_sum <= r_sum;
      end
   end

   assign result  = (r_state == S_ROLL) ? r_cnt : r_sum;
   assign die     = r_die;
   assign rolling = (r_state == S_ROLL);
   assign done    = (r_state == S_DONE);
   assign sat     = r_sat;

endmodule

// File: tb/tb_dice_roller_bcd.sv
// Bench for dice_roller_bcd: 3-digit and 2-digit instances share stimulus and
// are compared every cycle against an integer-arithmetic model of the rules.
module tb_dice_roller_bcd;

   localparam int DEB = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        accum = 1'b0;
   logic        clear = 1'b0;
   logic [5:0]  btn = 6'd0;
   logic [11:0] res3;
   logic [7:0]  res2;
   logic [2:0]  die3, die2;
   logic        rol3, rol2, done3, done2, sat3, sat2;
   logic [17:0] obs3, exp3;
   logic [12:0] obs2, exp2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dice_roller_bcd #(.DIGITS(3), .DEB_CYCLES(DEB)) u_d3 (
      .clk(clk), .rst(rst), .btn(btn), .accum(accum), .clear(clear),
      .result(res3), .die(die3), .rolling(rol3), .done(done3), .sat(sat3)
   );

   dice_roller_bcd #(.DIGITS(2), .DEB_CYCLES(DEB)) u_d2 (
      .clk(clk), .rst(rst), .btn(btn), .accum(accum), .clear(clear),
      .result(res2), .die(die2), .rolling(rol2), .done(done2), .sat(sat2)
   );

   assign obs3 = {res3, die3, rol3, done3, sat3};
   assign obs2 = {res2, die2, rol2, done2, sat2};

   // Model state: 0 idle, 1 roll, 2 done, 3 lock; counter and sums as integers.
   int m_st = 0, m_die = 0, m_cnt = 0;
   int m_lvl [6];
   int m_run [6];
   int m_sum [2];
   int m_sat [2];
   int NV  [6] = '{4, 6, 8, 10, 20, 100};
   int MOD [2] = '{1000, 100};

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      for (int d = 0; d < 4; d++) begin
         r[4*d +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic model_step();
      int any, nst, ndie, ncnt, r, s;
      logic [15:0] b3, b2;
      any = 0;
      for (int i = 0; i < 6; i++) any += m_lvl[i];
      if (rst) begin
         m_st = 0; m_die = 0; m_cnt = 0;
         for (int k = 0; k < 2; k++) begin m_sum[k] = 0; m_sat[k] = 0; end
         for (int i = 0; i < 6; i++) begin m_lvl[i] = 0; m_run[i] = 0; end
      end else begin
         nst = m_st; ndie = m_die; ncnt = m_cnt;
         case (m_st)
            0: if (any != 0) begin
                  for (int i = 5; i >= 0; i--) if (m_lvl[i] != 0) ndie = i;
                  ncnt = NV[ndie];
                  nst  = 1;
               end
            1: if (m_lvl[m_die] == 0) nst = 2;
               else ncnt = (m_cnt == 1) ? NV[m_die] : m_cnt - 1;
            2: begin
                  for (int k = 0; k < 2; k++) begin
                     r = m_cnt % MOD[k];
                     s = accum ? m_sum[k] + r : r;
                     if (s > MOD[k] - 1) begin s = MOD[k] - 1; m_sat[k] = 1; end
                     m_sum[k] = s;
                  end
                  nst = (any != 0) ? 3 : 0;
               end
            3: if (any == 0) nst = 0;
            default: nst = 0;
         endcase
         if (clear) for (int k = 0; k < 2; k++) begin m_sum[k] = 0; m_sat[k] = 0; end
         m_st = nst; m_die = ndie; m_cnt = ncnt;
         for (int i = 0; i < 6; i++) begin
            if (int'(btn[i]) != m_lvl[i]) begin
               m_run[i]++;
               if (m_run[i] == DEB) begin m_lvl[i] = int'(btn[i]); m_run[i] = 0; end
            end else begin
               m_run[i] = 0;
            end
         end
      end
      b3 = to_bcd(((m_st == 1) ? m_cnt : m_sum[0]) % MOD[0]);
      b2 = to_bcd(((m_st == 1) ? m_cnt : m_sum[1]) % MOD[1]);
      exp3 = {b3[11:0], 3'(m_die), (m_st == 1), (m_st == 2), 1'(m_sat[0])};
      exp2 = {b2[7:0],  3'(m_die), (m_st == 1), (m_st == 2), 1'(m_sat[1])};
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // Stimulus only: hold die d until release lands the roll on target.
   task automatic roll_to(input int d, input int target, output bit ok);
      int n;
      ok = 1'b0;
      btn = 6'(1 << d);
      n = 0;
      while (!(m_st == 1 && m_cnt == target + DEB) && n < 400) begin tick(); n++; end
      btn = 6'd0;
      n = 0;
      while (m_st != 0 && n < 30) begin tick(); n++; end
      ok = (m_st == 0);
   endtask

   task automatic test_reset();
      rst = 1'b1; btn = 6'd0; accum = 1'b0; clear = 1'b0;
      tick(); tick();
      checks++; if (obs3 !== 18'd0) begin errors++; $display("FAIL reset_d3: got %h want 0", obs3); end
      checks++; if (obs2 !== 13'd0) begin errors++; $display("FAIL reset_d2: got %h want 0", obs2); end
      checks++; if (obs3 !== exp3) begin errors++; $display("FAIL reset_model: got %h want %h", obs3, exp3); end
      rst = 1'b0;
   endtask

   task automatic test_glitch();
      bit rose = 1'b0;
      btn = 6'b000010;
      for (int c = 0; c < 13; c++) begin
         if (c == 3) btn = 6'd0;
         tick();
         rose |= rol3;
         checks++; if (obs3 !== exp3) begin errors++; $display("FAIL glitch_d3: got %h want %h", obs3, exp3); end
         checks++; if (obs2 !== exp2) begin errors++; $display("FAIL glitch_d2: got %h want %h", obs2, exp2); end
      end
      checks++;
      if (rose || res3 !== 12'h000) begin
         errors++; $display("FAIL glitch_roll: rolling=%0d result=%h want 0 and 000", rose, res3);
      end
   endtask

   task automatic test_d6_hold();
      int dones = 0, last = 0;
      bit seen = 1'b0;
      logic [15:0] tmp;
      btn = 6'b000010;
      for (int c = 0; c < 35; c++) begin
         if (c == 20) btn = 6'd0;
         tick();
         if (done3) dones++;
         if (m_st == 1) last = m_cnt;
         if (m_st == 1 && !seen) begin
            seen = 1'b1;
            checks++; if (res3 !== 12'h006) begin errors++; $display("FAIL d6_first: got %h want 006", res3); end
         end
         checks++; if (obs3 !== exp3) begin errors++; $display("FAIL d6_d3: got %h want %h", obs3, exp3); end
         checks++; if (obs2 !== exp2) begin errors++; $display("FAIL d6_d2: got %h want %h", obs2, exp2); end
      end
      tmp = to_bcd(last);
      checks++; if (dones != 1) begin errors++; $display("FAIL d6_done_count: got %0d want 1", dones); end
      checks++; if (res3 !== tmp[11:0] || rol3 !== 1'b0) begin
         errors++; $display("FAIL d6_sum: got %h rolling=%0d want %h rolling=0", res3, rol3, tmp[11:0]);
      end
   endtask

   task automatic test_priority();
      int dones = 0;
      btn = 6'b011000;
      for (int c = 0; c < 56; c++) begin
         if (c == 30) begin
            checks++; if (die3 !== 3'd3 || rol3 !== 1'b1) begin
               errors++; $display("FAIL prio_die: die=%0d rolling=%0d want 3 1", die3, rol3);
            end
            btn = 6'b001000;
         end
         if (c == 44) begin
            checks++; if (rol3 !== 1'b1) begin errors++; $display("FAIL prio_keep: rolling=%0d want 1", rol3); end
            btn = 6'd0;
         end
         tick();
         if (c >= 44 && done3) dones++;
         checks++; if (obs3 !== exp3) begin errors++; $display("FAIL prio_d3: got %h want %h", obs3, exp3); end
         checks++; if (obs2 !== exp2) begin errors++; $display("FAIL prio_d2: got %h want %h", obs2, exp2); end
      end
      checks++; if (dones != 1 || rol3 !== 1'b0) begin
         errors++; $display("FAIL prio_end: dones=%0d rolling=%0d want 1 0", dones, rol3);
      end
   endtask

   task automatic test_accum_sat();
      bit ok;
      clear = 1'b1; tick(); clear = 1'b0; accum = 1'b1;
      roll_to(5, 60, ok);
      checks++; if (!ok || res2 !== 8'h60 || res3 !== 12'h060) begin
         errors++; $display("FAIL acc_first: ok=%0d d2=%h d3=%h want 60 060", ok, res2, res3);
      end
      roll_to(5, 50, ok);
      checks++; if (!ok || res2 !== 8'h99 || sat2 !== 1'b1) begin
         errors++; $display("FAIL acc_sat_d2: ok=%0d got %h sat=%0d want 99 sat=1", ok, res2, sat2);
      end
      checks++; if (res3 !== 12'h110 || sat3 !== 1'b0) begin
         errors++; $display("FAIL acc_d3: got %h sat=%0d want 110 sat=0", res3, sat3);
      end
      checks++; if (obs2 !== exp2) begin errors++; $display("FAIL acc_model_d2: got %h want %h", obs2, exp2); end
      clear = 1'b1; tick(); clear = 1'b0; accum = 1'b0;
      checks++; if (res2 !== 8'h00 || sat2 !== 1'b0) begin
         errors++; $display("FAIL acc_clear: got %h sat=%0d want 00 sat=0", res2, sat2);
      end
   endtask

   task automatic test_d100_wrap();
      logic [11:0] prev = 12'h000;
      bit wrapped = 1'b0;
      btn = 6'b100000;
      for (int c = 0; c < 125; c++) begin
         if (c == 110) btn = 6'd0;
         prev = res3;
         tick();
         if (prev == 12'h001 && rol3) begin
            wrapped = 1'b1;
            checks++; if (res3 !== 12'h100) begin errors++; $display("FAIL d100_wrap: got %h want 100", res3); end
         end
         checks++; if (obs3 !== exp3) begin errors++; $display("FAIL d100_d3: got %h want %h", obs3, exp3); end
         checks++; if (obs2 !== exp2) begin errors++; $display("FAIL d100_d2: got %h want %h", obs2, exp2); end
      end
      checks++; if (!wrapped) begin errors++; $display("FAIL d100_seen: wrap 001->100 seen=0 want 1"); end
   endtask

   task automatic test_lock_reset();
      bit rose = 1'b0;
      int dones = 0;
      btn = 6'b100000;
      for (int c = 0; c < 45; c++) begin
         if (c == 10) btn = 6'b100001;
         if (c == 18) btn = 6'b000001;
         if (c == 25) btn = 6'b100001;
         if (c == 40) btn = 6'd0;
         tick();
         if (c >= 25) rose |= rol3;
         checks++; if (obs3 !== exp3) begin errors++; $display("FAIL lock_d3: got %h want %h", obs3, exp3); end
         checks++; if (obs2 !== exp2) begin errors++; $display("FAIL lock_d2: got %h want %h", obs2, exp2); end
      end
      checks++; if (rose) begin errors++; $display("FAIL lock_reroll: rolling rose in LOCK, want 0"); end
      btn = 6'b100000;
      repeat (12) tick();
      checks++; if (rol3 !== 1'b1) begin errors++; $display("FAIL lock_reroll_start: rolling=%0d want 1", rol3); end
      rst = 1'b1; btn = 6'd0;
      tick();
      rst = 1'b0;
      checks++; if (obs3 !== 18'd0 || obs2 !== 13'd0) begin
         errors++; $display("FAIL rst_mid_roll: d3=%h d2=%h want 0 0", obs3, obs2);
      end
      repeat (15) begin
         tick();
         if (done3 || done2) dones++;
      end
      checks++; if (dones != 0 || res3 !== 12'h000) begin
         errors++; $display("FAIL rst_no_done: dones=%0d result=%h want 0 000", dones, res3);
      end
   endtask

   task automatic test_reset_hold();
      rst = 1'b1; btn = 6'b000100;
      tick(); tick();
      rst = 1'b0;
      for (int c = 1; c <= DEB + 1; c++) begin
         tick();
         checks++; if (rol3 !== (c == DEB + 1)) begin
            errors++; $display("FAIL reset_hold_cycle%0d: rolling=%0d want %0d", c, rol3, (c == DEB + 1));
         end
      end
      checks++; if (obs3 !== exp3) begin errors++; $display("FAIL reset_hold_model: got %h want %h", obs3, exp3); end
      btn = 6'd0;
      repeat (10) tick();
   endtask

   task automatic test_random();
      int left = 0;
      for (int c = 0; c < 600; c++) begin
         if (left == 0) begin
            left = $urandom_range(1, 40);
            case ($urandom_range(0, 3))
               0:       btn = 6'd0;
               1:       btn = 6'(1 << $urandom_range(0, 5));
               2:       btn = 6'($urandom_range(0, 63));
               default: btn = btn;
            endcase
            accum = 1'($urandom_range(0, 1));
         end
         left--;
         clear = ($urandom_range(0, 24) == 0);
         rst   = ($urandom_range(0, 149) == 0);
         tick();
         checks++; if (obs3 !== exp3) begin errors++; $display("FAIL rand_d3 c%0d: got %h want %h", c, obs3, exp3); end
         checks++; if (obs2 !== exp2) begin errors++; $display("FAIL rand_d2 c%0d: got %h want %h", c, obs2, exp2); end
      end
      rst = 1'b0; clear = 1'b0; btn = 6'd0;
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_d6_hold();
      test_priority();
      test_accum_sat();
      test_d100_wrap();
      test_lock_reset();
      test_reset_hold();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/dice_roller_bcd.md
DICE_ROLLER_BCD -- requirements
Module: dice_roller_bcd

Interface
REQ-001 SHALL have parameter DIGITS, default 3: number of BCD result digits; legal range 2..4.
REQ-002 SHALL have parameter DEB_CYCLES, default 4: consecutive stable samples needed per button; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic rises on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port btn, input, 6 bits: raw die buttons, one per die, bit 0..5 = d4, d6, d8, d10, d20, d100.
REQ-006 SHALL have port accum, input, 1 bit: 1 = add each finished roll to the running sum; 0 = replace the sum.
REQ-007 SHALL have port clear, input, 1 bit: synchronous clear of the sum and the sat flag.
REQ-008 SHALL have port result, output, 4*DIGITS bits: BCD display value, least significant digit in bits [3:0].
REQ-009 SHALL have port die, output, 3 bits: index 0..5 of the latched die.
REQ-010 SHALL have port rolling, output, 1 bit: high while in ROLL.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a roll completes.
REQ-012 SHALL have port sat, output, 1 bit: sticky flag, set when the sum saturates.

Function
REQ-013 SHALL debounce each btn bit independently. Debounced level changes only after DEB_CYCLES consecutive raw samples differ from it. Any mismatch restarts that bit's counter.
REQ-014 SHALL implement states IDLE, ROLL, DONE and LOCK, with one-hot or binary encoding left free.
REQ-015 In IDLE, when any debounced button is high, the FSM SHALL go to ROLL.
- Latch die = lowest set debounced index (d4 highest priority).
- Load the roll counter with N(die) on the same edge.
REQ-016 Die size N SHALL be 4, 6, 8, 10, 20 or 100 for die 0..5.
REQ-017 When DIGITS=2, 100 SHALL be encoded as BCD 00.
REQ-018 In ROLL, the counter SHALL decrement by 1 in BCD every cycle. The cycle after value 1, it reloads N(die), giving the repeating sequence N, N-1, ..., 1.
REQ-019 ROLL SHALL exit to DONE on the first cycle where the debounced level of the latched die's button is 0. The counter holds its value on that edge.
REQ-020 In ROLL, other buttons SHALL be ignored: no die change and no reload.
REQ-021 DONE SHALL last exactly one cycle, with done=1. On that edge, with the roll value R = counter:
- accum=0: sum <= R.
- accum=1: sum <= sum + R (BCD add, all DIGITS digits).
REQ-022 If the BCD sum exceeds 10^DIGITS-1, sum SHALL saturate to all-9s and sat SHALL be set to 1.
REQ-023 From DONE, the FSM SHALL go to LOCK if any debounced button is high, else to IDLE.
REQ-024 The FSM SHALL leave LOCK for IDLE only when all debounced buttons are 0. This prevents re-roll without a full release.
REQ-025 result SHALL show the live counter while in ROLL and the sum in every other state.
REQ-026 clear=1 SHALL set sum=0 and sat=0 in any state. If clear coincides with the DONE update, clear SHALL win.
REQ-027 rolling SHALL be high exactly in ROLL. done SHALL be high exactly in DONE.
REQ-028 All outputs SHALL be registered or decoded only from state and registers, with no combinational path from btn.

Reset
REQ-029 On a clk edge with rst=1, the block SHALL enter IDLE and set:
- result=0, die=0, rolling=0, done=0, sat=0.
- Sum, counter, debounce counters and debounced levels all 0.
REQ-030 A reset during ROLL SHALL abort the roll. No done pulse and no sum update SHALL follow.
REQ-031 After reset is released, a button held continuously SHALL still need DEB_CYCLES samples before ROLL is entered.

Verification
REQ-032 Glitch rejection (DEB_CYCLES=4): btn[1] high for 3 cycles, then low -> rolling never rises; result stays 000.
REQ-033 d6 hold: btn[1] high for 20 cycles, then released -> result cycles 006, 005, ... 001, 006 ...; one done pulse; sum equals the last displayed value; then IDLE.
REQ-034 Priority: btn[3] and btn[4] rise together -> die=3; counter wraps 010 -> 009 ... 001 -> 010. Releasing btn[4] alone keeps ROLL; releasing btn[3] ends it.
REQ-035 Accumulate with saturation (DIGITS=2, accum=1): rolls producing 60, then 50 -> sum 60, then 99 with sat=1. clear -> result 00, sat=0.
REQ-036 d100 wrap (DIGITS=3): hold btn[5] -> 100, 099, ... 001, 100.
REQ-037 Lock: release d100, then hold btn[5] again within the LOCK window, and assert rst mid-ROLL on a later roll -> no second roll until full release; reset gives all outputs 0 and no done pulse.
